wb_burst_master: RTL and testbench

Wishbone B3 master that executes commanded single or incrementing-burst transfers against the on-chip register slaves (SPI control and peers). It sits between the host-side command logic and the Wishbone interconnect. It accepts one command (address, beat count, direction), streams write data in or read data out, and reports completion with a status code.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_master_timeout.sv | 24 ++
 rtl/wb_burst_master.sv | 190 +++++++++++++++++++
 tb/tb_wb_burst_master.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone cycle-type constants, completion status codes and master FSM states
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ERR     = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDAT,
        S_BUS,
        S_GAP,
        S_DONE
    } state_e;

endpackage

// File: rtl/wb_master_timeout.sv
// wb_master_timeout: counts consecutive stalled cycles and flags expiry on the TIMEOUT_CYC-th one
module wb_master_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i)
            cnt <= '0;
        else
            cnt <= (run && !clear) ? cnt + 1'b1 : '0;

    assign expired = run && !clear && cnt == CW'(TIMEOUT_CYC - 1);

endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 master running single or incrementing-burst commands.
// Optional stalled-slave abort is built in when WB_MASTER_TIMEOUT_EN is defined.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic             cmd_burst_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      wdat_i,
    input  logic             wdat_valid_i,
    output logic             wdat_ready_o,
    output logic [31:0]      rdat_o,
    output logic             rdat_valid_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [31:0]      adr_o,
    output logic [31:0]      dat_o,
    output logic [3:0]       sel_o,
    output logic [2:0]       cti_o,
    output logic [1:0]       bte_o,
    input  logic [31:0]      dat_i,
    input  logic             ack_i,
    input  logic             err_i,
    input  logic             rty_i
);

    state_e           state, state_d;
    status_e          status, status_d;
    logic             cyc, cyc_d, stb, stb_d, we, we_d, burst, burst_d;
    logic             gap_rty, gap_rty_d, rvalid_d, rdat_valid;
    logic [31:0]      adr, adr_d, dat, dat_d, rdat;
    logic [LEN_W-1:0] rem, rem_d;
    logic             last, pop, to_expired;

    assign last = rem == '0;

    // Every write-data pop in one place so the timeout reload never depends on its own output
    assign pop = wdat_valid_i && (
        (state == S_IDLE && cmd_valid_i && cmd_we_i) ||
        (state == S_WDAT) ||
        (state == S_GAP && we && !gap_rty) ||
        (state == S_BUS && ack_i && !err_i && !rty_i && we && burst && !last));

    always_comb begin
        state_d   = state;
        status_d  = status;
        cyc_d     = cyc;
        stb_d     = stb;
        we_d      = we;
        burst_d   = burst;
        gap_rty_d = gap_rty;
        adr_d     = adr;
        rem_d     = rem;
        rvalid_d  = 1'b0;
        dat_d     = pop ? wdat_i : dat;
        case (state)
            S_IDLE: if (cmd_valid_i) begin
                we_d     = cmd_we_i;
                burst_d  = cmd_burst_i;
                adr_d    = cmd_adr_i;
                rem_d    = cmd_len_i;
                status_d = ST_OK;
                cyc_d    = 1'b1;
                stb_d    = !cmd_we_i || wdat_valid_i;
                state_d  = (!cmd_we_i || wdat_valid_i) ? S_BUS : S_WDAT;
            end
            S_WDAT: if (wdat_valid_i) begin
                stb_d   = 1'b1;
                state_d = S_BUS;
            end else if (to_expired) begin
                cyc_d    = 1'b0;
                status_d = ST_TIMEOUT;
                state_d  = S_DONE;
            end
            S_BUS: if (err_i) begin
                cyc_d    = 1'b0;
                stb_d    = 1'b0;
                status_d = ST_ERR;
                state_d  = S_DONE;
            end else if (rty_i) begin
                cyc_d     = 1'b0;
                stb_d     = 1'b0;
                gap_rty_d = 1'b1;
                state_d   = S_GAP;
            end else if (ack_i) begin
                adr_d    = adr + 32'd4;
                rvalid_d = !we;
                if (last) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem - 1'b1;
                    if (!burst) begin
                        cyc_d     = 1'b0;
                        stb_d     = 1'b0;
                        gap_rty_d = 1'b0;
                        state_d   = S_GAP;
                    end else if (we && !wdat_valid_i) begin
                        stb_d   = 1'b0;
                        state_d = S_WDAT;
                    end
                end
            end else if (to_expired) begin
                cyc_d    = 1'b0;
                stb_d    = 1'b0;
                status_d = ST_TIMEOUT;
                state_d  = S_DONE;
            end
            S_GAP: begin
                cyc_d   = 1'b1;
                stb_d   = gap_rty || !we || wdat_valid_i;
                state_d = (gap_rty || !we || wdat_valid_i) ? S_BUS : S_WDAT;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state      <= S_IDLE;
            status     <= ST_OK;
            cyc        <= 1'b0;
            stb        <= 1'b0;
            we         <= 1'b0;
            burst      <= 1'b0;
            gap_rty    <= 1'b0;
            adr        <= '0;
            dat        <= '0;
            rem        <= '0;
            rdat       <= '0;
            rdat_valid <= 1'b0;
        end else begin
            state      <= state_d;
            status     <= status_d;
            cyc        <= cyc_d;
            stb        <= stb_d;
            we         <= we_d;
            burst      <= burst_d;
            gap_rty    <= gap_rty_d;
            adr        <= adr_d;
            dat        <= dat_d;
            rem        <= rem_d;
            rdat_valid <= rvalid_d;
            if (rvalid_d)
                rdat <= dat_i;
        end

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .run      (state == S_BUS || state == S_WDAT),
        .clear    (pop || (state == S_BUS && (ack_i || err_i || rty_i))),
        .expired  (to_expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYC;
    assign to_expired     = 1'b0;
`endif

    assign cmd_ready_o  = state == S_IDLE;
    assign wdat_ready_o = pop;
    assign done_o       = state == S_DONE;
    assign status_o     = status;
    assign rdat_o       = rdat;
    assign rdat_valid_o = rdat_valid;
    assign cyc_o        = cyc;
    assign stb_o        = stb;
    assign we_o         = we;
    assign adr_o        = adr;
    assign dat_o        = dat;
    assign sel_o        = 4'hF;
    assign bte_o        = BTE_LINEAR;
    assign cti_o        = !burst ? CTI_CLASSIC : last ? CTI_END : CTI_INCR;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed vectors and timing sequences for wb_burst_master
// against a one-cycle registered-ack slave model that returns adr ^ 0xD on reads.
module tb_wb_burst_master;

    localparam int LEN_W = 8;
    localparam int TO    = 16;

    logic             clk_i = 1'b0, reset_n_i = 1'b0;
    logic             cmd_valid_i = 1'b0, cmd_we_i = 1'b0, cmd_burst_i = 1'b0;
    logic [31:0]      cmd_adr_i = '0;
    logic [LEN_W-1:0] cmd_len_i = '0;
    logic [31:0]      wdat_i, rdat_o, adr_o, dat_o;
    logic             wdat_valid_i, wdat_ready_o, cmd_ready_o, rdat_valid_o, done_o;
    logic [1:0]       status_o, bte_o;
    logic             cyc_o, stb_o, we_o;
    logic [3:0]       sel_o;
    logic [2:0]       cti_o;
    logic [31:0]      dat_i = '0;
    logic             ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    wb_burst_master #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_burst_i(cmd_burst_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
        .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
        .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .sel_o(sel_o), .cti_o(cti_o), .bte_o(bte_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk_i = ~clk_i;

    // Slave: registered single-cycle termination, optional error/retry at a given acked-beat index
    int   err_at = -1, rty_at = -1, s_beat = 0;
    logic silent = 1'b0, s_rty_done = 1'b0;
    always @(posedge clk_i) begin
        if (cmd_valid_i && cmd_ready_o) begin
            s_beat     <= 0;
            s_rty_done <= 1'b0;
        end
        ack_i <= 1'b0;
        err_i <= 1'b0;
        rty_i <= 1'b0;
        if (cyc_o && stb_o && !ack_i && !err_i && !rty_i && !silent) begin
            if (s_beat == err_at)
                err_i <= 1'b1;
            else if (s_beat == rty_at && !s_rty_done) begin
                rty_i      <= 1'b1;
                s_rty_done <= 1'b1;
            end else begin
                ack_i  <= 1'b1;
                dat_i  <= adr_o ^ 32'hD;
                s_beat <= s_beat + 1;
            end
        end
    end

    // Write-data FIFO: tail moved by the stimulus, head by accepted pops
    logic [31:0] wmem [16];
    int          wt = 0, pop_cnt = 0;
    assign wdat_valid_i = pop_cnt != wt;
    assign wdat_i       = wmem[pop_cnt[3:0]];
    always @(posedge clk_i)
        if (wdat_ready_o && wdat_valid_i)
            pop_cnt <= pop_cnt + 1;

    task automatic push(input logic [31:0] v);
        wmem[wt[3:0]] = v;
        wt = wt + 1;
    endtask

    // Monitor, cleared on every command acceptance
    int          m_acks = 0, m_rv = 0, m_pops = 0, m_done = 0, m_rises = 0, m_gaps = 0;
    logic        m_prev_cyc = 1'b0, m_active = 1'b0;
    logic [1:0]  m_status = '0;
    logic [31:0] ack_adr [16], ack_dat [16], rd_log [16];
    logic [2:0]  ack_cti [16];
    always @(negedge clk_i) begin
        if (cmd_valid_i && cmd_ready_o) begin
            m_acks = 0; m_rv = 0; m_pops = 0; m_done = 0; m_rises = 0; m_gaps = 0;
            m_active = 1'b1;
        end else if (m_active && !cyc_o && !done_o)
            m_gaps++;
        if (wdat_ready_o && wdat_valid_i)
            m_pops++;
        if (cyc_o && !m_prev_cyc)
            m_rises++;
        if (stb_o && ack_i && !err_i && !rty_i && m_acks < 16) begin
            ack_adr[m_acks[3:0]] = adr_o;
            ack_cti[m_acks[3:0]] = cti_o;
            ack_dat[m_acks[3:0]] = dat_o;
            m_acks++;
        end
        if (rdat_valid_o && m_rv < 16) begin
            rd_log[m_rv[3:0]] = rdat_o;
            m_rv++;
        end
        if (done_o) begin
            m_done++;
            m_status = status_o;
            m_active = 1'b0;
        end
        m_prev_cyc = cyc_o;
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic w, input logic b, input logic [31:0] a, input int len);
        cmd_we_i    = w;
        cmd_burst_i = b;
        cmd_adr_i   = a;
        cmd_len_i   = LEN_W'(len);
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_o && n < 200) begin
            tick();
            n++;
        end
        chk({name, " done seen"}, 32'(done_o), 1);
    endtask

    typedef struct {
        logic        we;
        logic        burst;
        logic [31:0] adr;
        int          len, err_at, rty_at, stall_at;
        int          acks, rv, pops, st, rises, gaps;
    } vec_t;

    task automatic run_vec(input vec_t t, input int idx);
        string p;
        int    bp, n;
        p = $sformatf("v%0d", idx);
        err_at = t.err_at;
        rty_at = t.rty_at;
        wt     = pop_cnt;
        if (t.we)
            for (int k = 0; k <= t.len; k++)
                if (t.stall_at < 0 || k < t.stall_at)
                    push(32'(17 * (k + 1)));
        bp = pop_cnt;
        issue(t.we, t.burst, t.adr, t.len);
        if (t.stall_at >= 0) begin
            n = 0;
            while (pop_cnt != bp + t.stall_at && n < 50) begin
                tick();
                n++;
            end
            repeat (6) tick();
            chk({p, " stall stb"}, 32'(stb_o), 0);
            chk({p, " stall cyc"}, 32'(cyc_o), 1);
            chk({p, " stall adr"}, adr_o, t.adr + 32'(4 * t.stall_at));
            for (int k = t.stall_at; k <= t.len; k++)
                push(32'(17 * (k + 1)));
        end
        wait_done(p);
        repeat (3) tick();
        chk({p, " acks"}, 32'(m_acks), 32'(t.acks));
        chk({p, " rdat_valid"}, 32'(m_rv), 32'(t.rv));
        chk({p, " pops"}, 32'(m_pops), 32'(t.pops));
        chk({p, " status"}, 32'(m_status), 32'(t.st));
        chk({p, " cyc rises"}, 32'(m_rises), 32'(t.rises));
        chk({p, " gaps"}, 32'(m_gaps), 32'(t.gaps));
        chk({p, " done count"}, 32'(m_done), 1);
        for (int k = 0; k < t.acks && k < m_acks; k++) begin
            chk($sformatf("%s b%0d adr", p, k), ack_adr[k[3:0]], t.adr + 32'(4 * k));
            chk($sformatf("%s b%0d cti", p, k), 32'(ack_cti[k[3:0]]),
                !t.burst ? 0 : (k == t.len ? 7 : 2));
            if (t.we)
                chk($sformatf("%s b%0d dat", p, k), ack_dat[k[3:0]], 32'(17 * (k + 1)));
            else if (k < m_rv)
                chk($sformatf("%s b%0d rdat", p, k), rd_log[k[3:0]], (t.adr + 32'(4 * k)) ^ 32'hD);
        end
    endtask

    vec_t v [9];

    initial begin
        v[0] = '{1'b0, 1'b0, 32'h0000_0008, 0, -1, -1, -1, 1, 1, 0, 0, 1, 0};
        v[1] = '{1'b1, 1'b1, 32'h0000_0100, 3, -1, -1, -1, 4, 0, 4, 0, 1, 0};
        v[2] = '{1'b1, 1'b1, 32'h0000_0100, 3, -1, -1,  2, 4, 0, 4, 0, 1, 0};
        v[3] = '{1'b0, 1'b1, 32'h0000_0200, 3,  1, -1, -1, 1, 1, 0, 1, 1, 0};
        v[4] = '{1'b0, 1'b0, 32'h0000_0020, 0, -1,  0, -1, 1, 1, 0, 0, 2, 1};
        v[5] = '{1'b1, 1'b0, 32'h0000_0040, 2, -1, -1, -1, 3, 0, 3, 0, 3, 2};
        v[6] = '{1'b0, 1'b1, 32'h0000_0300, 0, -1, -1, -1, 1, 1, 0, 0, 1, 0};
        v[7] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 3, -1, -1, -1, 4, 4, 0, 0, 1, 0};
        v[8] = '{1'b1, 1'b1, 32'h0000_0500, 3, -1,  1, -1, 4, 0, 4, 0, 2, 1};

        repeat (2) tick();
        chk("rst cyc", 32'(cyc_o), 0);
        chk("rst stb", 32'(stb_o), 0);
        chk("rst we", 32'(we_o), 0);
        chk("rst adr", adr_o, 0);
        chk("rst dat", dat_o, 0);
        chk("rst cti", 32'(cti_o), 0);
        chk("rst sel", 32'(sel_o), 32'hF);
        chk("rst bte", 32'(bte_o), 0);
        chk("rst rdat", rdat_o, 0);
        chk("rst rdat_valid", 32'(rdat_valid_o), 0);
        chk("rst done", 32'(done_o), 0);
        chk("rst status", 32'(status_o), 0);
        chk("rst wdat_ready", 32'(wdat_ready_o), 0);
        reset_n_i = 1'b1;
        tick();
        chk("rst cmd_ready", 32'(cmd_ready_o), 1);

        // Cycle-exact timing of a 2-beat burst read
        issue(1'b0, 1'b1, 32'h80, 1);
        chk("t1 cyc", 32'(cyc_o), 1);
        chk("t1 stb", 32'(stb_o), 1);
        chk("t1 adr", adr_o, 32'h80);
        chk("t1 cti", 32'(cti_o), 2);
        tick();
        chk("t2 ack", 32'(ack_i), 1);
        tick();
        chk("t3 rdat_valid", 32'(rdat_valid_o), 1);
        chk("t3 rdat", rdat_o, 32'h8D);
        chk("t3 adr", adr_o, 32'h84);
        chk("t3 cti", 32'(cti_o), 7);
        chk("t3 stb", 32'(stb_o), 1);
        tick();
        chk("t4 ack", 32'(ack_i), 1);
        chk("t4 done", 32'(done_o), 0);
        tick();
        chk("t5 done", 32'(done_o), 1);
        chk("t5 status", 32'(status_o), 0);
        chk("t5 cyc", 32'(cyc_o), 0);
        chk("t5 rdat", rdat_o, 32'h89);
        chk("t5 cmd_ready", 32'(cmd_ready_o), 0);
        tick();
        chk("t6 cmd_ready", 32'(cmd_ready_o), 1);
        chk("t6 done", 32'(done_o), 0);
        tick();

        for (int i = 0; i < 9; i++)
            run_vec(v[i], i);

        // Error on second beat: cycle drops next cycle, status holds until next accept
        err_at = 1;
        rty_at = -1;
        issue(1'b0, 1'b1, 32'h200, 3);
        repeat (2) tick();
        chk("e3 rdat_valid", 32'(rdat_valid_o), 1);
        tick();
        chk("e4 err", 32'(err_i), 1);
        tick();
        chk("e5 cyc", 32'(cyc_o), 0);
        chk("e5 stb", 32'(stb_o), 0);
        chk("e5 done", 32'(done_o), 1);
        chk("e5 status", 32'(status_o), 1);
        chk("e5 rdat_valid", 32'(rdat_valid_o), 0);
        repeat (2) tick();
        chk("e7 status held", 32'(status_o), 1);
        err_at = -1;
        issue(1'b0, 1'b0, 32'h8, 0);
        chk("e status cleared", 32'(status_o), 0);
        wait_done("e next");
        repeat (2) tick();

        // Silent slave
        silent = 1'b1;
        issue(1'b0, 1'b1, 32'h600, 3);
        begin
            int n;
            n = 1;
            while (!done_o && n < 40) begin
                tick();
                n++;
            end
`ifdef WB_MASTER_TIMEOUT_EN
            chk("to done", 32'(done_o), 1);
            chk("to cycle", 32'(n), TO + 1);
            chk("to status", 32'(status_o), 2);
            chk("to cyc", 32'(cyc_o), 0);
`else
            chk("stall no done", 32'(done_o), 0);
            chk("stall cyc", 32'(cyc_o), 1);
            chk("stall stb", 32'(stb_o), 1);
            chk("stall adr", adr_o, 32'h600);
`endif
        end
        #2 reset_n_i = 1'b0;
        #1;
        chk("stall rst cyc", 32'(cyc_o), 0);
        silent = 1'b0;
        tick();
        reset_n_i = 1'b1;
        repeat (2) tick();

        // Reset asserted mid-burst drops the cycle asynchronously and produces no done
        issue(1'b0, 1'b1, 32'h700, 3);
        repeat (2) tick();
        chk("mr cyc before", 32'(cyc_o), 1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("mr cyc", 32'(cyc_o), 0);
        chk("mr stb", 32'(stb_o), 0);
        chk("mr rdat_valid", 32'(rdat_valid_o), 0);
        repeat (2) tick();
        reset_n_i = 1'b1;
        repeat (6) tick();
        chk("mr no done", 32'(m_done), 0);
        chk("mr cmd_ready", 32'(cmd_ready_o), 1);
        chk("mr status", 32'(status_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected to have finished");
        $fatal(1);
    end

endmodule
